// File: rtl/vfpu_unpack_pipe_pkg.sv
// -----------------------------------------------------------------------------
// vfpu_unpack_pipe_pkg
//   Shared definitions for the vector FPU operand unpacker.
//   - cls_e          : class codes reported per lane (codes 6-7 unused)
//   - exp_bias_of()  : IEEE-754 exponent bias for a given exponent width
//   - lane_width()   : packed operand width, sign + exponent + fraction
//   Optional feature macro used by the design files: VFPU_UNPACK_NORM_EN.
// -----------------------------------------------------------------------------
package vfpu_unpack_pipe_pkg;

    typedef enum logic [2:0] {
        CLS_ZERO   = 3'd0,
        CLS_DENORM = 3'd1,
        CLS_NORM   = 3'd2,
        CLS_INF    = 3'd3,
        CLS_QNAN   = 3'd4,
        CLS_SNAN   = 3'd5
    } cls_e;

    // bias = 2^(exp_w-1) - 1
    function automatic int exp_bias_of(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int lane_width(input int exp_w, input int frac_w);
        return 1 + exp_w + frac_w;
    endfunction

endpackage

// File: rtl/vfpu_unpack_pipe_lane.sv
// -----------------------------------------------------------------------------
// vfpu_unpack_lane
//   Combinational single-lane IEEE-754 unpack + classify.
//   Macro VFPU_UNPACK_NORM_EN: when defined, a non-flushed denormal is
//   normalised in the same cycle (leading-zero count inside this module);
//   exp_bias_o still reports 1 and cls_o stays DENORM.
//
// Ports:
//   op_i        in   packed operand {sign, exponent, fraction}
//   nj_i        in   flush-denormal mode
//   s_o         out  sign bit (kept even for flushed values)
//   exp_bias_o  out  effective biased exponent, unsigned
//   exp_o       out  unbiased exponent, two's complement, EXP_W+1 bits
//   frac_o      out  fraction with explicit leading bit, FRAC_W+1 bits
//   cls_o       out  class code (vfpu_unpack_pipe_pkg::cls_e)
// -----------------------------------------------------------------------------
module vfpu_unpack_lane
    import vfpu_unpack_pipe_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic [EXP_W+FRAC_W:0] op_i,
    input  logic                  nj_i,
    output logic                  s_o,
    output logic [EXP_W-1:0]      exp_bias_o,
    output logic [EXP_W:0]        exp_o,
    output logic [FRAC_W:0]       frac_o,
    output logic [2:0]            cls_o
);

    localparam int             BIAS   = exp_bias_of(EXP_W);
    localparam logic [EXP_W:0] BIAS_X = (EXP_W+1)'(BIAS);

    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;
    logic              e_zero;
    logic              e_ones;
    logic              f_zero;

    assign s_o    = op_i[EXP_W+FRAC_W];
    assign e      = op_i[EXP_W+FRAC_W-1 -: EXP_W];
    assign f      = op_i[FRAC_W-1:0];
    assign e_zero = (e == '0);
    assign e_ones = (e == '1);
    assign f_zero = (f == '0);

`ifdef VFPU_UNPACK_NORM_EN
    localparam int LZ_W = $clog2(FRAC_W + 1);

    logic [LZ_W-1:0] lz;

    // Scan from LSB upward so the highest set bit is the last one to win.
    always_comb begin
        lz = LZ_W'(FRAC_W);
        for (int i = 0; i < FRAC_W; i++) begin
            if (f[i]) lz = LZ_W'(FRAC_W - 1 - i);
        end
    end
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        exp_bias_o = e;
        frac_o     = {1'b1, f};
        cls_o      = CLS_NORM;

        if (e_zero) begin
            if (f_zero) begin
                exp_bias_o = '0;
                cls_o      = CLS_ZERO;
            end else if (nj_i) begin
                exp_bias_o = '0;
                frac_o     = '0;
                cls_o      = CLS_ZERO;
            end else begin
                // Denormals share the exponent of the smallest normal.
                exp_bias_o = EXP_W'(1);
                frac_o     = {1'b0, f};
                cls_o      = CLS_DENORM;
            end
        end else if (e_ones) begin
            if (f_zero)            cls_o = CLS_INF;
            else if (f[FRAC_W-1])  cls_o = CLS_QNAN;
            else                   cls_o = CLS_SNAN;
        end

        // Zero-extended before the subtraction so all-ones stays positive.
        exp_o = {1'b0, exp_bias_o} - BIAS_X;

`ifdef VFPU_UNPACK_NORM_EN
        if (e_zero && !f_zero && !nj_i) begin
            // {0,f} << (lz+1) == {f,0} << lz; exp = 1 - bias - (lz+1).
            frac_o = {f, 1'b0} << lz;
            exp_o  = -BIAS_X - (EXP_W+1)'(lz);
        end
`endif
    end

endmodule

// File: rtl/vfpu_unpack_pipe.sv
// -----------------------------------------------------------------------------
// vfpu_unpack_pipe
//   Multi-lane IEEE-754 operand unpacker, one registered stage with a
//   valid/ready handshake. Lanes are unpacked by vfpu_unpack_lane; this level
//   only holds the handshake and the output registers.
//   Macro VFPU_UNPACK_NORM_EN (see vfpu_unpack_lane) enables same-cycle
//   normalisation of denormals; latency and handshake are unchanged.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   upstream transaction valid
//   in_ready   out  block can accept this cycle (0 while in reset)
//   nj_mode    in   flush-denormal mode, common to all lanes
//   operand    in   packed operands, lane i at [i*W +: W]
//   out_valid  out  output transaction valid
//   out_ready  in   downstream accepts the output
//   s          out  sign per lane
//   exp_bias   out  effective biased exponent per lane
//   exp        out  unbiased exponent per lane, two's complement
//   frac       out  fraction with explicit leading bit per lane
//   cls        out  class code per lane
// -----------------------------------------------------------------------------
module vfpu_unpack_pipe
    import vfpu_unpack_pipe_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int LANES  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          nj_mode,
    input  logic [LANES*(1+EXP_W+FRAC_W)-1:0] operand,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES-1:0]              s,
    output logic [LANES*EXP_W-1:0]        exp_bias,
    output logic [LANES*(EXP_W+1)-1:0]    exp,
    output logic [LANES*(FRAC_W+1)-1:0]   frac,
    output logic [LANES*3-1:0]            cls
);

    localparam int W = lane_width(EXP_W, FRAC_W);

    logic [LANES-1:0]            s_d,        s_q;
    logic [LANES*EXP_W-1:0]      exp_bias_d, exp_bias_q;
    logic [LANES*(EXP_W+1)-1:0]  exp_d,      exp_q;
    logic [LANES*(FRAC_W+1)-1:0] frac_d,     frac_q;
    logic [LANES*3-1:0]          cls_d,      cls_q;
    logic                        valid_q;
    logic                        accept;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        vfpu_unpack_lane #(
            .EXP_W  (EXP_W),
            .FRAC_W (FRAC_W)
        ) u_lane (
            .op_i       (operand[i*W +: W]),
            .nj_i       (nj_mode),
            .s_o        (s_d[i]),
            .exp_bias_o (exp_bias_d[i*EXP_W +: EXP_W]),
            .exp_o      (exp_d[i*(EXP_W+1) +: EXP_W+1]),
            .frac_o     (frac_d[i*(FRAC_W+1) +: FRAC_W+1]),
            .cls_o      (cls_d[i*3 +: 3])
        );
    end

    // Ready whenever the register is empty or being drained this cycle.
    assign in_ready = rst_n & (~valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        // NOTE: data registers are cleared too, because outputs must read 0 after reset.
        if (!rst_n) begin
            valid_q    <= 1'b0;
            s_q        <= '0;
            exp_bias_q <= '0;
            exp_q      <= '0;
            frac_q     <= '0;
            cls_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            if (accept) begin
                valid_q    <= 1'b1;
                s_q        <= s_d;
                exp_bias_q <= exp_bias_d;
                exp_q      <= exp_d;
                frac_q     <= frac_d;
                cls_q      <= cls_d;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = valid_q;
    assign s         = s_q;
    assign exp_bias  = exp_bias_q;
    assign exp       = exp_q;
    assign frac      = frac_q;
    assign cls       = cls_q;

endmodule

// File: tb/tb_vfpu_unpack_pipe.sv
// -----------------------------------------------------------------------------
// tb_vfpu_unpack_pipe
//   Self-checking bench for vfpu_unpack_pipe (EXP_W=8, FRAC_W=23, LANES=4).
//   Expected results come from an arithmetic reference model and a queue of
//   accepted transactions; directed vectors are also checked against literals.
// -----------------------------------------------------------------------------
module tb_vfpu_unpack_pipe;

    localparam int EW    = 8;
    localparam int FW    = 23;
    localparam int L     = 4;
    localparam int W     = 1 + EW + FW;
    localparam int BIAS  = 127;
    localparam int EMAX  = 255;
    localparam int HID   = 1 << FW;

    typedef struct packed {
        logic              s;
        logic [EW-1:0]     eb;
        logic signed [EW:0] ex;
        logic [FW:0]       fr;
        logic [2:0]        cl;
    } lane_t;

    typedef lane_t [L-1:0] txn_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic                nj_mode;
    logic [L*W-1:0]      operand;
    logic                out_valid;
    logic                out_ready;
    logic [L-1:0]        s;
    logic [L*EW-1:0]     exp_bias;
    logic [L*(EW+1)-1:0] exp;
    logic [L*(FW+1)-1:0] frac;
    logic [L*3-1:0]      cls;

    int   n_tests = 0;
    int   n_fail  = 0;
    txn_t q[$];

    vfpu_unpack_pipe #(.EXP_W(EW), .FRAC_W(FW), .LANES(L)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .nj_mode   (nj_mode),
        .operand   (operand),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .exp_bias  (exp_bias),
        .exp       (exp),
        .frac      (frac),
        .cls       (cls)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 500us");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", tag, got, got, want, want);
        end
    endtask

    // Reference model: decode by value ranges, then normalise by doubling.
    function automatic lane_t ref_lane(input logic [W-1:0] x, input bit nj);
        lane_t r;
        int    e, f, eb, ex, fr, cl;
        bit    denorm_kept;
        e  = int'(x >> FW) % (EMAX + 1);
        f  = int'(x % HID);
        denorm_kept = 1'b0;
        if (e == 0 && f == 0) begin
            eb = 0; fr = HID; cl = 0;
        end else if (e == 0 && nj) begin
            eb = 0; fr = 0; cl = 0;
        end else if (e == 0) begin
            eb = 1; fr = f; cl = 1; denorm_kept = 1'b1;
        end else if (e == EMAX) begin
            eb = e; fr = HID + f;
            cl = (f == 0) ? 3 : ((f >= HID / 2) ? 4 : 5);
        end else begin
            eb = e; fr = HID + f; cl = 2;
        end
        ex = eb - BIAS;
`ifdef VFPU_UNPACK_NORM_EN
        if (denorm_kept) begin
            while (fr < HID) begin
                fr = fr * 2;
                ex = ex - 1;
            end
        end
`else
        if (denorm_kept) ex = ex;
`endif
        r.s  = (x >= (1 << (W - 1)));
        r.eb = EW'(eb);
        r.ex = (EW+1)'(ex);
        r.fr = (FW+1)'(fr);
        r.cl = 3'(cl);
        return r;
    endfunction

    function automatic txn_t ref_txn(input logic [L*W-1:0] op, input bit nj);
        txn_t t;
        for (int i = 0; i < L; i++) t[i] = ref_lane(op[i*W +: W], nj);
        return t;
    endfunction

    function automatic logic [W-1:0] rand_op();
        logic [EW-1:0] e;
        logic [FW-1:0] f;
        logic          sg;
        int            k;
        e  = EW'($urandom);
        f  = FW'($urandom);
        sg = 1'($urandom);
        k  = $urandom_range(0, 6);
        case (k)
            0: e = '0;
            1: begin e = '0; f = '0; end
            2: e = '1;
            3: begin e = '1; f = '0; end
            4: begin e = '0; f = FW'(1) << $urandom_range(0, FW - 1); end
            default: if (e == '0 || e == '1) e = EW'(1);
        endcase
        return {sg, e, f};
    endfunction

    function automatic logic [L*W-1:0] rand_txn();
        logic [L*W-1:0] v;
        for (int i = 0; i < L; i++) v[i*W +: W] = rand_op();
        return v;
    endfunction

    task automatic check_txn(input txn_t t);
        for (int i = 0; i < L; i++) begin
            check($sformatf("l%0d.s", i),        s[i],                        t[i].s);
            check($sformatf("l%0d.exp_bias", i), exp_bias[i*EW +: EW],        t[i].eb);
            check($sformatf("l%0d.exp", i),      $signed(exp[i*(EW+1) +: EW+1]), t[i].ex);
            check($sformatf("l%0d.frac", i),     frac[i*(FW+1) +: FW+1],      t[i].fr);
            check($sformatf("l%0d.cls", i),      cls[i*3 +: 3],               t[i].cl);
        end
    endtask

    task automatic check_lane(input string tag, input int i, input int s_w, input int eb_w,
                              input int ex_w, input int fr_w, input int cl_w);
        check({tag, ".s"},        s[i],                           s_w);
        check({tag, ".exp_bias"}, exp_bias[i*EW +: EW],           eb_w);
        check({tag, ".exp"},      $signed(exp[i*(EW+1) +: EW+1]), ex_w);
        check({tag, ".frac"},     frac[i*(FW+1) +: FW+1],         fr_w);
        check({tag, ".cls"},      cls[i*3 +: 3],                  cl_w);
    endtask

    // Apply inputs just after a falling edge, advance one cycle, check outputs.
    task automatic drive(input bit v, input bit nj, input logic [L*W-1:0] op,
                         input bit ordy, output bit acc);
        bit exp_rdy;
        in_valid  = v;
        nj_mode   = nj;
        operand   = op;
        out_ready = ordy;
        #1;
        exp_rdy = (q.size() == 0) || ordy;
        check("in_ready", in_ready, exp_rdy);
        acc = v && exp_rdy;
        if (q.size() != 0 && ordy) void'(q.pop_front());
        if (acc) q.push_back(ref_txn(op, nj));
        @(posedge clk);
        @(negedge clk);
        check("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) check_txn(q[0]);
    endtask

    task automatic check_reset_state();
        check("rst.out_valid", out_valid, 0);
        check("rst.in_ready",  in_ready,  0);
        check("rst.s",         s,         0);
        check("rst.exp_bias",  exp_bias,  0);
        check("rst.exp",       exp,       0);
        check("rst.frac",      frac,      0);
        check("rst.cls",       cls,       0);
    endtask

    initial begin
        bit             acc;
        logic [L*W-1:0] hold;
        int             n_acc;
        int             n_out;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; nj_mode = 1'b0; operand = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_reset_state();
        rst_n = 1'b1;

        // Basic lanes: 1.0, -1.0, +0, +Inf.
        drive(1, 0, {32'h7F800000, 32'h00000000, 32'hBF800000, 32'h3F800000}, 1, acc);
        check_lane("one",  0, 0, 'h7F,    0, 'h800000, 2);
        check_lane("mone", 1, 1, 'h7F,    0, 'h800000, 2);
        check_lane("zero", 2, 0, 'h00, -127, 'h800000, 0);
        check_lane("inf",  3, 0, 'hFF,  128, 'h800000, 3);

        drive(1, 0, {4{32'h00000001}}, 1, acc);
`ifdef VFPU_UNPACK_NORM_EN
        check_lane("dn", 0, 0, 1, -149, 'h800000, 1);
`else
        check_lane("dn", 0, 0, 1, -126, 'h000001, 1);
`endif
        drive(1, 1, {4{32'h80000001}}, 1, acc);
        check_lane("flush", 2, 1, 0, -127, 0, 0);
        drive(1, 0, {32'h7F800001, 32'h7FC00000, 32'h7F800001, 32'h7FC00000}, 1, acc);
        check_lane("qnan", 0, 0, 'hFF, 128, 'hC00000, 4);
        check_lane("snan", 1, 0, 'hFF, 128, 'h800001, 5);
        drive(0, 0, '0, 1, acc);

        // in_valid held for 5 cycles, out_ready low from cycle 2; data held until accepted.
        n_acc = 0;
        n_out = 0;
        hold  = rand_txn();
        for (int c = 0; c < 8; c++) begin
            bit ordy;
            bit v;
            ordy = (c == 0) || (c >= 5);
            v    = (c < 5);
            if (q.size() != 0 && ordy) n_out++;
            drive(v, 1'($urandom), hold, ordy, acc);
            if (acc) begin
                n_acc++;
                hold = rand_txn();
            end
        end
        check("stall.drained", q.size(), 0);
        check("stall.count",   n_out,    n_acc);

        // Full throughput: one result per cycle.
        n_acc = 0;
        for (int c = 0; c < 200; c++) begin
            drive(1, 1'($urandom), rand_txn(), 1, acc);
            if (acc) n_acc++;
        end
        check("thru.accepts", n_acc, 200);

        // Random handshake traffic.
        hold = rand_txn();
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), hold,
                  1'($urandom_range(0, 2) != 0), acc);
            if (acc) hold = rand_txn();
        end

        // Reset while a result is held.
        drive(1, 0, rand_txn(), 1, acc);
        drive(0, 0, '0, 0, acc);
        check("pre_rst.out_valid", out_valid, 1);
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_state();
        q.delete();
        rst_n = 1'b1;
        drive(1, 0, rand_txn(), 0, acc);
        check("post_rst.accept", acc, 1);
        drive(0, 0, '0, 1, acc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
